// File: rtl/rad4_booth_seq_mul.sv
// Sequential radix-4 Booth multiplier: one Booth digit per clock, returns a P_W-bit product slice.
// Optional round-half-up of the slice when RAD4_SEQ_ROUND_EN is defined.
module rad4_booth_seq_mul #(
  parameter int unsigned X_W   = 32,
  parameter int unsigned Y_W   = 11,
  parameter int unsigned P_W   = 32,
  parameter int unsigned P_LSB = 10
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [X_W-1:0] x,
  input  logic [Y_W-1:0] y,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [P_W-1:0] p
);

  localparam int unsigned N     = (Y_W + 1) / 2;
  localparam int unsigned YS_W  = 2 * N;
  localparam int unsigned YQ_W  = YS_W + 1;
  localparam int unsigned ACC_W = X_W + 2 * N + 1;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

`ifdef RAD4_SEQ_ROUND_EN
  localparam logic [ACC_W-1:0] RoundConst =
      (P_LSB > 0) ? (ACC_W'(1) << ((P_LSB > 0) ? (P_LSB - 1) : 0)) : '0;
`else
  localparam logic [ACC_W-1:0] RoundConst = '0;
`endif

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [X_W-1:0]   x_q, x_d;
  logic [YQ_W-1:0]  y_q, y_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [P_W-1:0]   p_q, p_d;

  logic             dig_zero, dig_neg, dig_two;
  logic [ACC_W-1:0] x_ext, mag, term, sum, sum_rnd;

  // y_q is shifted right two bits per digit, so the current triplet is always y_q[2:0].
  always_comb begin
    dig_zero = 1'b0;
    dig_neg  = 1'b0;
    dig_two  = 1'b0;
    unique case (y_q[2:0])
      3'b000, 3'b111: dig_zero = 1'b1;
      3'b001, 3'b010: begin end
      3'b011:         dig_two = 1'b1;
      3'b100: begin
        dig_neg = 1'b1;
        dig_two = 1'b1;
      end
      3'b101, 3'b110: dig_neg = 1'b1;
      default: begin end
    endcase
  end

  always_comb begin
    x_ext   = ACC_W'($signed(x_q));
    mag     = dig_two ? (x_ext << 1) : x_ext;
    term    = dig_zero ? '0 : (dig_neg ? (~mag + ACC_W'(1)) : mag);
    sum     = acc_q + (term << {cnt_q, 1'b0});
    sum_rnd = sum + RoundConst;
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    x_d     = x_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          x_d     = x;
          y_d     = {YS_W'($signed(y)), 1'b0};
          acc_d   = '0;
          cnt_d   = '0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        acc_d = sum;
        y_d   = y_q >> 2;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(N - 1)) begin
          p_d     = P_W'(sum_rnd >> P_LSB);
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      acc_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign p         = p_q;

endmodule

// File: tb/tb_rad4_booth_seq_mul.sv
// Directed bench for rad4_booth_seq_mul at default widths; expectations follow RAD4_SEQ_ROUND_EN.
module tb_rad4_booth_seq_mul;

  localparam int unsigned X_W   = 32;
  localparam int unsigned Y_W   = 11;
  localparam int unsigned P_W   = 32;
  localparam int unsigned P_LSB = 10;
  localparam int unsigned N     = (Y_W + 1) / 2;
`ifdef RAD4_SEQ_ROUND_EN
  localparam bit Rnd = 1'b1;
`else
  localparam bit Rnd = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [X_W-1:0] x;
  logic [Y_W-1:0] y;
  logic           out_valid;
  logic           out_ready;
  logic [P_W-1:0] p;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rad4_booth_seq_mul #(
    .X_W  (X_W),
    .Y_W  (Y_W),
    .P_W  (P_W),
    .P_LSB(P_LSB)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .x        (x),
    .y        (y),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .p        (p)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [P_W-1:0] model(input logic [X_W-1:0] xv, input logic [Y_W-1:0] yv);
    longint prod;
    prod = longint'($signed(xv)) * longint'($signed(yv));
    if (Rnd) prod += longint'(1) << (P_LSB - 1);
    model = P_W'(prod >>> P_LSB);
  endfunction

  // Runs one operation from #1 after a rising edge; stall holds out_ready low for that many
  // cycles while a competing in_valid is presented.
  task automatic do_op(input string tag, input logic [X_W-1:0] xv, input logic [Y_W-1:0] yv,
                       input logic [P_W-1:0] exp, input int stall);
    int lat;
    int w;
    x         = xv;
    y         = yv;
    in_valid  = 1'b1;
    out_ready = (stall == 0);
    w = 0;
    while (!in_ready && w < 40) begin
      @(posedge clk); #1;
      w++;
    end
    check_eq({tag, " accept"}, 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    x        = $urandom;
    y        = Y_W'($urandom);
    check_eq({tag, " busy in_ready"}, 64'(in_ready), 64'd0);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq({tag, " latency"}, 64'(lat), 64'(N));
    check_eq({tag, " p"}, 64'(p), 64'(exp));
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1;
      @(posedge clk); #1;
      check_eq({tag, " stall out_valid"}, 64'(out_valid), 64'd1);
      check_eq({tag, " stall p"}, 64'(p), 64'(exp));
      check_eq({tag, " stall in_ready"}, 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_eq({tag, " drop out_valid"}, 64'(out_valid), 64'd0);
    check_eq({tag, " idle in_ready"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [X_W-1:0] rx;
    logic [Y_W-1:0] ry;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    x         = '0;
    y         = '0;
    #1;
    check_eq("reset in_ready", 64'(in_ready), 64'd1);
    check_eq("reset out_valid", 64'(out_valid), 64'd0);
    check_eq("reset p", 64'(p), 64'd0);
    #11 rst_n = 1'b1;
    @(posedge clk); #1;

    do_op("t1", 32'h0000_0400, 11'd1, 32'h0000_0001, 0);
    do_op("t2a", 32'hFFFF_FFFF, 11'h400, 32'h0000_0001, 0);
    do_op("t2b", 32'h7FFF_FFFF, 11'h3FF, 32'h7FDF_FFFF, 0);
    do_op("t3a", 32'h0000_0200, 11'd1, Rnd ? 32'h1 : 32'h0, 0);
    do_op("t3b", 32'h0000_01FF, 11'd1, 32'h0, 0);
    do_op("ext_nn", 32'h8000_0000, 11'h400, 32'h8000_0000, 0);
    do_op("ext_np", 32'h8000_0000, 11'h3FF, 32'h8020_0000, 0);
    do_op("neg_small", 32'd100, 11'h7FD, Rnd ? 32'h0 : 32'hFFFF_FFFF, 0);
    do_op("zero_y", 32'h1234_5678, 11'd0, 32'h0, 0);
    do_op("neg_one", 32'h0010_0000, 11'h7FF, 32'hFFFF_FC00, 0);
    do_op("mixed", 32'd3000, 11'd500, Rnd ? 32'h5B9 : 32'h5B8, 0);
    do_op("t4", 32'h7FFF_FFFF, 11'h3FF, 32'h7FDF_FFFF, 5);
    do_op("after_t4", 32'd3000, 11'd500, Rnd ? 32'h5B9 : 32'h5B8, 0);

    // Abandon an operation at cnt==3; p still holds the previous nonzero result.
    x        = 32'h0000_0400;
    y        = 11'd1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t5 rst out_valid", 64'(out_valid), 64'd0);
    check_eq("t5 rst p", 64'(p), 64'd0);
    check_eq("t5 rst in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("t5 no emit", 64'(out_valid), 64'd0);
    do_op("t5 post", 32'hFFFF_FFFF, 11'h400, 32'h0000_0001, 0);

    for (int i = 0; i < 100; i++) begin
      rx = $urandom;
      ry = Y_W'($urandom);
      do_op("rand", rx, ry, model(rx, ry), int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
